timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Countdown kitchen-style timer controller.
// Holds a user setpoint (edited in 10 s steps), counts it down once per
// prescaled second, raises an alarm for a fixed number of seconds at zero,
// and drives a registered BCD mm:ss display plus state/status flags.
module timer_ctrl #(
  parameter int TICK_DIV   = 12000000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       set_p,
  input  logic       inc_p,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [2:0] mode,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Two-digit BCD decrement; 00 wraps to 59 (seconds borrow).
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00) begin
      r = 8'h59;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Two-digit BCD minute increment; 59 wraps to 00.
  function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Setpoint +10 s: seconds ones digit is always zero here, so only
  // the tens digit moves; x:50 carries into the minutes.
  function automatic logic [15:0] setpt_add10(input logic [7:0] mn, input logic [7:0] sc);
    logic [15:0] r;
    if (sc[7:4] >= 4'd5) begin
      r = {bcd_inc_min(mn), 8'h00};
    end else begin
      r = {mn, sc[7:4] + 4'd1, 4'd0};
    end
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    set_min_r, set_sec_r, set_min_s, set_sec_s;
  logic [7:0]    cnt_min_r, cnt_sec_r, cnt_min_s, cnt_sec_s;
  logic [PW-1:0] presc_r, presc_s, presc_adv_s;
  logic [AW-1:0] alarm_cnt_r, alarm_cnt_s;
  logic [7:0]    dec_min_s, dec_sec_s, disp_min_s, disp_sec_s;
  logic          tick_s, setpt_zero_s, dec_zero_s;

  // Shared helpers: tick detect, prescaler advance, one-second count decrement.
  always_comb begin
    tick_s       = (presc_r == PRESC_MAX);
    presc_adv_s  = tick_s ? {PW{1'b0}} : presc_r + PW'(1);
    setpt_zero_s = (set_min_r == 8'h00) && (set_sec_r == 8'h00);
    dec_sec_s    = bcd_dec(cnt_sec_r);
    dec_min_s    = (cnt_sec_r == 8'h00) ? bcd_dec(cnt_min_r) : cnt_min_r;
    dec_zero_s   = (dec_min_s == 8'h00) && (dec_sec_s == 8'h00);
  end

  // Next-state and datapath update; pulse priority is set > start > inc.
  always_comb begin
    state_s     = state_r;
    set_min_s   = set_min_r;
    set_sec_s   = set_sec_r;
    cnt_min_s   = cnt_min_r;
    cnt_sec_s   = cnt_sec_r;
    presc_s     = presc_r;
    alarm_cnt_s = alarm_cnt_r;
    case (state_r)
      ST_IDLE, ST_SET: begin
        presc_s = {PW{1'b0}};
        if (set_p) begin
          state_s = (state_r == ST_IDLE) ? ST_SET : ST_IDLE;
        end else if (start_p) begin
          if (!setpt_zero_s) begin
            state_s   = ST_RUN;
            cnt_min_s = set_min_r;
            cnt_sec_s = set_sec_r;
          end else begin
            state_s = state_r;
          end
        end else if (inc_p && (state_r == ST_SET)) begin
          {set_min_s, set_sec_s} = setpt_add10(set_min_r, set_sec_r);
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (set_p) begin
          state_s = ST_IDLE;
          presc_s = {PW{1'b0}};
        end else if (start_p) begin
          // Pausing wins over a coincident tick: prescaler and count hold.
          state_s = ST_PAUSE;
        end else begin
          presc_s = presc_adv_s;
          if (tick_s) begin
            cnt_min_s = dec_min_s;
            cnt_sec_s = dec_sec_s;
            if (dec_zero_s) begin
              state_s     = ST_DONE;
              alarm_cnt_s = {AW{1'b0}};
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_PAUSE: begin
        if (set_p) begin
          state_s = ST_IDLE;
          presc_s = {PW{1'b0}};
        end else if (start_p) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        cnt_min_s = 8'h00;
        cnt_sec_s = 8'h00;
        if (set_p || start_p || inc_p) begin
          state_s = ST_IDLE;
          presc_s = {PW{1'b0}};
        end else begin
          presc_s = presc_adv_s;
          if (tick_s) begin
            if (alarm_cnt_r == ALARM_LAST) begin
              state_s     = ST_IDLE;
              alarm_cnt_s = {AW{1'b0}};
            end else begin
              alarm_cnt_s = alarm_cnt_r + AW'(1);
            end
          end else begin
            alarm_cnt_s = alarm_cnt_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        presc_s = {PW{1'b0}};
      end
    endcase
  end

  // Display source follows the state being entered.
  always_comb begin
    if ((state_s == ST_IDLE) || (state_s == ST_SET)) begin
      disp_min_s = set_min_s;
      disp_sec_s = set_sec_s;
    end else begin
      disp_min_s = cnt_min_s;
      disp_sec_s = cnt_sec_s;
    end
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      set_min_r   <= 8'h00;
      set_sec_r   <= 8'h00;
      cnt_min_r   <= 8'h00;
      cnt_sec_r   <= 8'h00;
      presc_r     <= {PW{1'b0}};
      alarm_cnt_r <= {AW{1'b0}};
      min_bcd     <= 8'h00;
      sec_bcd     <= 8'h00;
      mode        <= 3'd0;
      running     <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state_r     <= state_s;
      set_min_r   <= set_min_s;
      set_sec_r   <= set_sec_s;
      cnt_min_r   <= cnt_min_s;
      cnt_sec_r   <= cnt_sec_s;
      presc_r     <= presc_s;
      alarm_cnt_r <= alarm_cnt_s;
      min_bcd     <= disp_min_s;
      sec_bcd     <= disp_sec_s;
      mode        <= state_s;
      running     <= (state_s == ST_RUN);
      alarm       <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl (TICK_DIV=4, ALARM_SECS=3).
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_p = 1'b0;
  logic       set_p = 1'b0;
  logic       inc_p = 1'b0;
  logic [7:0] min_bcd, sec_bcd;
  logic [2:0] mode;
  logic       running, alarm;

  timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .set_p(set_p), .inc_p(inc_p),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode), .running(running), .alarm(alarm)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] m;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       run;
    logic       alm;
    string      nm;
  } exp_t;

  typedef struct {
    logic       r, s, st, in;
    logic [2:0] m;
    logic [7:0] mn, sc;
    string      nm;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic exp_t mk(input logic [2:0] m, input logic [7:0] mn, input logic [7:0] sc, input string nm);
    exp_t e;
    e.m = m; e.mn = mn; e.sc = sc;
    e.run = (m == 3'd2);
    e.alm = (m == 3'd4);
    e.nm = nm;
    return e;
  endfunction

  // One clock of stimulus; optionally queue an expectation and compare after the edge.
  task automatic step(input logic r, input logic s, input logic st, input logic in,
                      input logic chk, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst_n = r; set_p = s; start_p = st; inc_p = in;
    if (chk) sb_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1; set_p = 1'b0; start_p = 1'b0; inc_p = 1'b0;
    if (chk) begin
      x = sb_q.pop_front();
      checks++;
      if (mode !== x.m || min_bcd !== x.mn || sec_bcd !== x.sc || running !== x.run || alarm !== x.alm) begin
        failures++;
        $display("FAIL %s: got mode=%0d %h:%h running=%b alarm=%b, expected mode=%0d %h:%h running=%b alarm=%b",
                 x.nm, mode, min_bcd, sec_bcd, running, alarm, x.m, x.mn, x.sc, x.run, x.alm);
      end
    end
  endtask

  task automatic go(input logic s, input logic st, input logic in, input logic [2:0] m,
                    input logic [7:0] mn, input logic [7:0] sc, input string nm);
    step(1'b1, s, st, in, 1'b1, mk(m, mn, sc, nm));
  endtask

  task automatic quiet(input logic s, input logic st, input logic in);
    step(1'b1, s, st, in, 1'b0, mk(3'd0, 8'h00, 8'h00, ""));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(3'd0, 8'h00, 8'h00, "reset"));
  endtask

  initial begin
    // Table: setpoint editing and pulse priority.
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, "reset_state"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, "enter_set"});
    for (int i = 1; i <= 7; i++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, to_bcd((i * 10) / 60), to_bcd((i * 10) % 60), "set_inc"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h10, "leave_set"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h10, "idle_inc_ignored"});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h01, 8'h10, "set_beats_start"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h01, 8'h10, "start_beats_inc"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h10, "run_abort"});
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].s, tbl[i].st, tbl[i].in, 1'b1, mk(tbl[i].m, tbl[i].mn, tbl[i].sc, tbl[i].nm));

    // 59:50 wraps to 00:00; start with a zero setpoint is ignored.
    do_reset();
    quiet(1'b1, 1'b0, 1'b0);
    repeat (358) quiet(1'b0, 1'b0, 1'b1);
    go(1'b0, 1'b0, 1'b1, 3'd1, 8'h59, 8'h50, "setpt_5950");
    go(1'b0, 1'b0, 1'b1, 3'd1, 8'h00, 8'h00, "setpt_wrap");
    go(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, "wrap_leave_set");
    go(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, "zero_start_ignored");

    // 00:20 full run, alarm, auto-return; model checks every cycle.
    do_reset();
    quiet(1'b1, 1'b0, 1'b0);
    quiet(1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h20, "run_start");
    for (int k = 1; k <= 92; k++) begin
      int left;
      left = (k <= 80) ? 20 - k / 4 : 0;
      if (k == 92)
        go(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h20, "alarm_timeout");
      else
        go(1'b0, 1'b0, 1'b0, (left == 0) ? 3'd4 : 3'd2, 8'h00, to_bcd(left), "countdown");
    end

    // 01:00: borrow, pause coincident with tick, resume.
    do_reset();
    quiet(1'b1, 1'b0, 1'b0);
    repeat (6) quiet(1'b0, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 3'd2, 8'h01, 8'h00, "run_0100");
    repeat (3) go(1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 8'h00, "pre_tick");
    go(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h59, "borrow");
    repeat (3) quiet(1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 8'h59, "pause_on_tick");
    for (int k = 0; k < 100; k++) go(1'b0, 1'b0, (k == 50), 3'd3, 8'h00, 8'h59, "pause_hold");
    go(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h59, "resume");
    go(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h58, "resume_tick");
    repeat (3) go(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h58, "resume_hold");
    go(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h57, "resume_tick2");
    go(1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00, "run_set_start");

    // DONE exit on inc_p, then reset mid-run with start_p high.
    do_reset();
    quiet(1'b1, 1'b0, 1'b0);
    quiet(1'b0, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h10, "run_0010");
    repeat (39) quiet(1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 8'h00, "done_entry");
    go(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h10, "done_inc_exit");
    go(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h10, "rerun");
    repeat (2) quiet(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(3'd0, 8'h00, 8'h00, "reset_mid_run"));
    go(1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, "setpoint_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
